// File: rtl/coin_pkg.sv
// ============================================================================
// Module  : coin_pkg
// Brief   : Shared types and coin values for the coin acceptor and vending machine.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package coin_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DEB_HI = 2'd1,
        HELD   = 2'd2,
        DEB_LO = 2'd3
    } chute_state_t;

    typedef enum logic [1:0] {
        COIN_NICKEL  = 2'd0,
        COIN_DIME    = 2'd1,
        COIN_QUARTER = 2'd2
    } coin_idx_t;

    localparam int NUM_CHUTES    = 3;
    localparam int NICKEL_CENTS  = 5;
    localparam int DIME_CENTS    = 10;
    localparam int QUARTER_CENTS = 25;

endpackage

`default_nettype wire

// File: rtl/coin_debounce.sv
// ============================================================================
// Module  : coin_debounce
// Brief   : Synchronizer, debounce FSM and jam timer for a single coin chute.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module coin_debounce
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int JAM_CYCLES      = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_event,
    output logic o_jam_flag
);

    localparam logic [7:0]  c_DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] c_JAM_MAX  = 16'(JAM_CYCLES);

    logic [1:0]   r_sync;
    logic         w_s;
    chute_state_t r_state;
    chute_state_t w_state_nxt;
    logic [7:0]   r_cnt;
    logic [7:0]   w_cnt_nxt;
    logic [15:0]  r_hold;
    logic [15:0]  w_hold_nxt;
    logic [15:0]  w_hold_inc;
    logic         r_event;
    logic         w_event_nxt;

    assign w_s        = r_sync[1];
    assign w_hold_inc = (r_hold == c_JAM_MAX) ? r_hold : r_hold + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= 2'b00;
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_hold  <= 16'd0;
            r_event <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_raw};
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hold  <= w_hold_nxt;
            r_event <= w_event_nxt;
        end
    end

    // The hold timer keeps running through DEB_LO so a bouncing release
    // cannot reset an in-progress jam.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hold_nxt  = r_hold;
        w_event_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                w_hold_nxt = 16'd0;
                if (w_s) begin
                    w_state_nxt = DEB_HI;
                    w_cnt_nxt   = 8'd1;
                end
            end
            DEB_HI: begin
                if (!w_s) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == c_DEB_LAST) begin
                    w_state_nxt = HELD;
                    w_event_nxt = 1'b1;
                    w_hold_nxt  = 16'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            HELD: begin
                w_hold_nxt = w_hold_inc;
                if (!w_s) begin
                    w_state_nxt = DEB_LO;
                    w_cnt_nxt   = 8'd1;
                end
            end
            DEB_LO: begin
                w_hold_nxt = w_hold_inc;
                if (w_s) begin
                    w_state_nxt = HELD;
                end else if (r_cnt == c_DEB_LAST) begin
                    w_state_nxt = IDLE;
                    w_hold_nxt  = 16'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o_event    = r_event;
    assign o_jam_flag = (r_hold == c_JAM_MAX);

endmodule

`default_nettype wire

// File: rtl/coin_acceptor.sv
// ============================================================================
// Module  : coin_acceptor
// Brief   : Three debounced coin chutes arbitrated into single-cycle strobes.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module coin_acceptor
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int JAM_CYCLES      = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_nickel,
    input  logic raw_dime,
    input  logic raw_quarter,
    input  logic accept_en,
    output logic nickel,
    output logic dime,
    output logic quarter,
    output logic return_coin,
    output logic jam
);

    logic [NUM_CHUTES-1:0] w_raw;
    logic [NUM_CHUTES-1:0] w_events;
    logic [NUM_CHUTES-1:0] w_jam;
    logic                  w_any;
    logic                  w_single;
    logic                  w_accept;

    assign w_raw = {raw_quarter, raw_dime, raw_nickel};

    for (genvar i = 0; i < NUM_CHUTES; i++) begin : g_chute
        coin_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .JAM_CYCLES     (JAM_CYCLES)
        ) u_deb (
            .clk       (clk),
            .rst       (reset),
            .i_raw     (w_raw[i]),
            .o_event   (w_events[i]),
            .o_jam_flag(w_jam[i])
        );
    end

    // Simultaneous events are ambiguous: refund rather than guess a value.
    assign w_any    = |w_events;
    assign w_single = w_any && ((w_events & (w_events - 3'd1)) == 3'd0);
    assign w_accept = w_single && accept_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nickel      <= 1'b0;
            dime        <= 1'b0;
            quarter     <= 1'b0;
            return_coin <= 1'b0;
            jam         <= 1'b0;
        end else begin
            nickel      <= w_accept && w_events[COIN_NICKEL];
            dime        <= w_accept && w_events[COIN_DIME];
            quarter     <= w_accept && w_events[COIN_QUARTER];
            return_coin <= w_any && !w_accept;
            jam         <= |w_jam;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_coin_acceptor.sv
// ============================================================================
// Module  : tb_coin_acceptor
// Brief   : Scoreboard bench for coin_acceptor strobes, refunds and jam flag.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_coin_acceptor;

    localparam int DEB = 4;
    localparam int JAM = 50;
    localparam int LAT = DEB + 3;

    localparam logic [3:0] K_N = 4'b0001;
    localparam logic [3:0] K_D = 4'b0010;
    localparam logic [3:0] K_Q = 4'b0100;
    localparam logic [3:0] K_R = 4'b1000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic raw_nickel = 1'b0;
    logic raw_dime = 1'b0;
    logic raw_quarter = 1'b0;
    logic accept_en = 1'b1;
    logic nickel, dime, quarter, return_coin, jam;

    always #5 clk = ~clk;

    coin_acceptor #(
        .DEBOUNCE_CYCLES(DEB),
        .JAM_CYCLES     (JAM)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .raw_nickel (raw_nickel),
        .raw_dime   (raw_dime),
        .raw_quarter(raw_quarter),
        .accept_en  (accept_en),
        .nickel     (nickel),
        .dime       (dime),
        .quarter    (quarter),
        .return_coin(return_coin),
        .jam        (jam)
    );

    typedef struct {
        int         cyc;
        logic [3:0] kind;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // A raw line changed at this negedge is first captured on the next edge k;
    // the strobe is then visible one cycle after edge k+DEB+2.
    task automatic expect_at(input int dly, input logic [3:0] kind);
        q.push_back('{cyc + dly, kind});
    endtask

    always @(negedge clk) begin
        logic [3:0] obs;
        exp_t       e;
        obs = {return_coin, quarter, dime, nickel};
        if (obs !== 4'b0000) begin
            if (q.size() == 0) begin
                check("spurious_strobe", {28'd0, obs}, 32'd0);
            end else begin
                e = q.pop_front();
                check("strobe_kind", {28'd0, obs}, {28'd0, e.kind});
                check("strobe_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int c0;

        step(3);
        check("reset_outputs", {27'd0, return_coin, quarter, dime, nickel, jam}, 32'd0);
        reset = 1'b0;
        step(3);

        // clean dime
        raw_dime = 1'b1;
        expect_at(LAT, K_D);
        step(20);
        raw_dime = 1'b0;
        step(12);

        // quarter bouncing on insertion and on release
        raw_quarter = 1'b1; step(1);
        raw_quarter = 1'b0; step(1);
        raw_quarter = 1'b1; step(1);
        raw_quarter = 1'b0; step(1);
        raw_quarter = 1'b1;
        expect_at(LAT, K_Q);
        step(10);
        raw_quarter = 1'b0; step(1);
        raw_quarter = 1'b1; step(1);
        raw_quarter = 1'b0; step(1);
        raw_quarter = 1'b1; step(1);
        raw_quarter = 1'b0;
        step(12);

        // short pulses: 2 and DEB-1 samples give nothing, DEB samples give one
        raw_quarter = 1'b1; step(2);
        raw_quarter = 1'b0; step(10);
        raw_quarter = 1'b1; step(DEB - 1);
        raw_quarter = 1'b0; step(10);
        raw_quarter = 1'b1;
        expect_at(LAT, K_Q);
        step(DEB);
        raw_quarter = 1'b0; step(14);

        // coin returned while not accepting
        accept_en = 1'b0;
        raw_nickel = 1'b1;
        expect_at(LAT, K_R);
        step(10);
        raw_nickel = 1'b0;
        step(12);
        accept_en = 1'b1;

        // simultaneous nickel and dime
        raw_nickel = 1'b1;
        raw_dime = 1'b1;
        expect_at(LAT, K_R);
        step(10);
        raw_nickel = 1'b0;
        raw_dime = 1'b0;
        step(12);

        // nickel then dime one cycle apart: two separate strobes
        raw_nickel = 1'b1;
        expect_at(LAT, K_N);
        step(1);
        raw_dime = 1'b1;
        expect_at(LAT, K_D);
        step(10);
        raw_nickel = 1'b0;
        raw_dime = 1'b0;
        step(12);

        // jammed nickel; dime still accepted meanwhile
        c0 = cyc;
        raw_nickel = 1'b1;
        expect_at(LAT, K_N);
        step(56);
        check("jam_before", {31'd0, jam}, 32'd0);
        step(1);
        check("jam_rise", {31'd0, jam}, 32'd1);
        step(1);
        raw_dime = 1'b1;
        expect_at(LAT, K_D);
        step(2);
        raw_nickel = 1'b0;
        step(6);
        check("jam_hold", {31'd0, jam}, 32'd1);
        check("jam_fall_cycle", cyc - c0, 32'd66);
        step(1);
        check("jam_fall", {31'd0, jam}, 32'd0);
        step(1);
        raw_dime = 1'b0;
        step(12);

        // reset while a chute is jammed and the quarter is mid-debounce
        raw_nickel = 1'b1;
        expect_at(LAT, K_N);
        step(58);
        check("jam_pre_reset", {31'd0, jam}, 32'd1);
        raw_quarter = 1'b1;
        step(3);
        reset = 1'b1;
        #1;
        check("reset_async", {27'd0, return_coin, quarter, dime, nickel, jam}, 32'd0);
        raw_nickel = 1'b0;
        step(2);
        reset = 1'b0;
        expect_at(LAT, K_Q);
        step(10);
        check("jam_after_reset", {31'd0, jam}, 32'd0);
        raw_quarter = 1'b0;
        step(15);

        check("scoreboard_empty", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
